vram_arb: RTL and testbench

- Parametrised multi-client successor to the single-port video RAM.
- Holds a DEPTH-word video memory with per-nibble write masking. Arbitrates up to NUM_CH requesters (channel 0 = display fetch, others = host/blitter/copper) onto the one memory port.
- Each cycle, at most one access is granted. Read data returns on a shared bus, qualified per channel, after a fixed latency.

---
 rtl/vram_arb.sv | 113 +++++++++++
 tb/tb_vram_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arb.sv
// Multi-channel video RAM arbiter: fixed-priority channel 0, round-robin 1..NUM_CH-1,
// nibble-masked writes and a fixed-latency shared read-data return bus.
module vram_arb #(
  parameter int NUM_CH = 3,
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1,
  localparam int MW    = DW / 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    req,
  input  logic [NUM_CH-1:0]    wr_en,
  input  logic [NUM_CH*MW-1:0] wr_mask,
  input  logic [NUM_CH*AW-1:0] addr,
  input  logic [NUM_CH*DW-1:0] wr_data,
  output logic [NUM_CH-1:0]    ack,
  output logic [NUM_CH-1:0]    rd_valid,
  output logic [DW-1:0]        rd_data
);

  localparam int DEPTH = 2 ** AW;
  localparam int PW    = $clog2(NUM_CH);

  logic [DW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_rr_ptr;
  logic [NUM_CH-1:0] r_vld1;
  logic [DW-1:0]     r_rd_q;

  logic [NUM_CH-1:0] w_grant;
  logic [PW-1:0]     w_sel;
  logic [PW-1:0]     w_idx;
  logic              w_found;
  logic [AW-1:0]     w_addr;
  logic [DW-1:0]     w_wdata;
  logic [MW-1:0]     w_mask;
  logic              w_wr;
  logic              w_rd;
  logic [NUM_CH-1:0] w_vld_out;
  logic [DW-1:0]     w_data_out;

  // Channel 0 wins outright; otherwise scan 1..NUM_CH-1 starting just after r_rr_ptr.
  always_comb begin
    w_grant = '0;
    w_sel   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    if (!reset) begin
      if (req[0]) begin
        w_grant[0] = 1'b1;
        w_found    = 1'b1;
      end else begin
        for (int k = 1; k < NUM_CH; k++) begin
          w_idx = PW'(((int'(r_rr_ptr) - 1 + k) % (NUM_CH - 1)) + 1);
          if (!w_found && req[w_idx]) begin
            w_grant[w_idx] = 1'b1;
            w_sel          = w_idx;
            w_found        = 1'b1;
          end
        end
      end
    end
  end

  assign ack     = w_grant;
  assign w_addr  = addr[int'(w_sel)*AW +: AW];
  assign w_wdata = wr_data[int'(w_sel)*DW +: DW];
  assign w_mask  = wr_mask[int'(w_sel)*MW +: MW];
  assign w_wr    = w_found & wr_en[w_sel];
  assign w_rd    = w_found & ~wr_en[w_sel];

  // Array has no reset; only one access per cycle so read and write never collide.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int n = 0; n < MW; n++) begin
        if (w_mask[n]) r_mem[w_addr][n*4 +: 4] <= w_wdata[n*4 +: 4];
      end
    end
    if (w_rd) r_rd_q <= r_mem[w_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= PW'(NUM_CH - 1);
      r_vld1   <= '0;
    end else begin
      r_vld1 <= w_rd ? w_grant : '0;
      if (w_found && (w_sel != '0)) r_rr_ptr <= w_sel;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [NUM_CH-1:0] r_vld2;
      logic [DW-1:0]     r_rd_q2;
      always_ff @(posedge clk) begin
        if (reset) r_vld2 <= '0;
        else       r_vld2 <= r_vld1;
        if (|r_vld1) r_rd_q2 <= r_rd_q;
      end
      assign w_vld_out  = r_vld2;
      assign w_data_out = r_rd_q2;
    end else begin : g_lat1
      assign w_vld_out  = r_vld1;
      assign w_data_out = r_rd_q;
    end
  endgenerate

  // Masking with reset drops a read whose return would land during reset.
  assign rd_valid = w_vld_out & {NUM_CH{~reset}};
  assign rd_data  = w_data_out;

endmodule

// File: tb/tb_vram_arb.sv
// Bench for vram_arb: two instances (RD_LAT 1 and 2, NUM_CH 4) share stimulus and are
// checked against a queue-based arbitration/memory model, a vector table and directed cases.
module tb_vram_arb;

  localparam int NC = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  wr_en;
  logic [15:0] wr_mask;
  logic [63:0] addr;
  logic [63:0] wr_data;
  logic [3:0]  ack1, ack2, rv1, rv2;
  logic [15:0] rd1, rd2;

  vram_arb #(.NUM_CH(NC), .AW(16), .DW(16), .RD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .req(req), .wr_en(wr_en), .wr_mask(wr_mask),
    .addr(addr), .wr_data(wr_data), .ack(ack1), .rd_valid(rv1), .rd_data(rd1));

  vram_arb #(.NUM_CH(NC), .AW(16), .DW(16), .RD_LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .req(req), .wr_en(wr_en), .wr_mask(wr_mask),
    .addr(addr), .wr_data(wr_data), .ack(ack2), .rd_valid(rv2), .rd_data(rd2));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          due;
    int          ch;
    logic [15:0] data;
  } rd_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_ack;
  } vec_t;

  logic [15:0] mem_m [int];
  int          prio_q[$];
  rd_t         exp_q1[$];
  rd_t         exp_q2[$];
  int          step_n;
  int          total;
  int          bad;
  logic [15:0] obs1, obs2;
  logic [3:0]  obs_ack;
  vec_t        tbl[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, step_n, act, exp);
    end
  endtask

  // Priority among channels 1..NC-1 is a rotating list; the granted channel goes to the back.
  task automatic model_reset();
    prio_q.delete();
    for (int c = 1; c < NC; c++) prio_q.push_back(c);
  endtask

  function automatic int model_grant(input logic [3:0] rq);
    if (rq[0]) return 0;
    foreach (prio_q[i]) if (rq[prio_q[i]]) return prio_q[i];
    return -1;
  endfunction

  // driver + per-cycle scoreboard
  task automatic step(input logic rst, input logic [3:0] rq, input logic [3:0] we,
                      input logic [15:0] msk, input logic [63:0] ad, input logic [63:0] dt);
    int          g;
    int          t;
    logic [3:0]  ea;
    logic [3:0]  ev;
    logic [15:0] ed;
    logic [15:0] a;
    logic [15:0] w;
    rd_t         r;
    reset = rst; req = rq; wr_en = we; wr_mask = msk; addr = ad; wr_data = dt;
    @(negedge clk);
    if (rst) begin
      exp_q1.delete();
      exp_q2.delete();
      g = -1;
    end else begin
      g = model_grant(rq);
    end
    ea = (g >= 0) ? 4'(1 << g) : 4'b0;
    chk("ack_lat1", 64'(ack1), 64'(ea));
    chk("ack_lat2", 64'(ack2), 64'(ea));
    obs_ack = ack1;

    ev = '0; ed = '0;
    if (exp_q1.size() > 0 && exp_q1[0].due == step_n) begin
      r = exp_q1.pop_front(); ev = 4'(1 << r.ch); ed = r.data;
    end
    chk("rd_valid_lat1", 64'(rv1), 64'(ev));
    if (ev != 0) chk("rd_data_lat1", 64'(rd1), 64'(ed));
    ev = '0; ed = '0;
    if (exp_q2.size() > 0 && exp_q2[0].due == step_n) begin
      r = exp_q2.pop_front(); ev = 4'(1 << r.ch); ed = r.data;
    end
    chk("rd_valid_lat2", 64'(rv2), 64'(ev));
    if (ev != 0) chk("rd_data_lat2", 64'(rd2), 64'(ed));
    obs1 = rd1;
    obs2 = rd2;

    if (g >= 0) begin
      a = ad[g*16 +: 16];
      if (we[g]) begin
        w = mem_m.exists(int'(a)) ? mem_m[int'(a)] : 16'h0000;
        for (int n = 0; n < 4; n++) if (msk[g*4+n]) w[n*4 +: 4] = dt[g*16 + n*4 +: 4];
        mem_m[int'(a)] = w;
      end else begin
        r.ch = g; r.data = mem_m[int'(a)];
        r.due = step_n + 1; exp_q1.push_back(r);
        r.due = step_n + 2; exp_q2.push_back(r);
      end
      if (g >= 1) begin
        while (prio_q[0] != g) begin
          t = prio_q.pop_front();
          prio_q.push_back(t);
        end
        t = prio_q.pop_front();
        prio_q.push_back(t);
      end
    end
    if (rst) model_reset();
    @(posedge clk);
    #1;
    step_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'b0, 4'b0, 16'h0, 64'h0, 64'h0);
  endtask

  initial begin
    logic [63:0] ad;
    logic [63:0] dt;
    total = 0; bad = 0; step_n = 0;
    obs1 = '0; obs2 = '0; obs_ack = '0;
    model_reset();

    // priority hold then round-robin, starting from reset rotation state
    for (int i = 0; i < 6; i++) tbl[i] = '{4'b0111, 4'b0001};
    tbl[6]  = '{4'b0110, 4'b0010};
    tbl[7]  = '{4'b1110, 4'b0100};
    tbl[8]  = '{4'b1110, 4'b1000};
    tbl[9]  = '{4'b1110, 4'b0010};
    tbl[10] = '{4'b1110, 4'b0100};
    tbl[11] = '{4'b1111, 4'b0001};
    tbl[12] = '{4'b1110, 4'b1000};
    tbl[13] = '{4'b1110, 4'b0010};
    tbl[14] = '{4'b1010, 4'b1000};
    tbl[15] = '{4'b0000, 4'b0000};
    tbl[16] = '{4'b1100, 4'b0100};
    tbl[17] = '{4'b1010, 4'b1000};

    for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 4'b0, 16'h0, 64'h0, 64'h0);
    idle(1);

    for (int i = 0; i < 8; i++)
      step(1'b0, 4'b0001, 4'b0001, 16'h000F, 64'(i), 64'(16'h1111 * (i + 1)));

    for (int i = 0; i < 18; i++) begin
      step(1'b0, tbl[i].req, 4'b0, 16'h0, {16'd3, 16'd2, 16'd1, 16'd0}, 64'h0);
      chk("table_ack", 64'(obs_ack), 64'(tbl[i].exp_ack));
    end
    idle(3);

    // pipelined reads from three channels on consecutive cycles
    step(1'b0, 4'b0001, 4'b0, 16'h0, {16'd0, 16'd0, 16'd0, 16'd0}, 64'h0);
    step(1'b0, 4'b0010, 4'b0, 16'h0, {16'd0, 16'd0, 16'd1, 16'd0}, 64'h0);
    step(1'b0, 4'b0100, 4'b0, 16'h0, {16'd0, 16'd2, 16'd0, 16'd0}, 64'h0);
    idle(3);

    // masked writes, then a zero-mask write that must change nothing
    step(1'b0, 4'b0010, 4'b0010, 16'h00F0, 64'h0000_0000_1234_0000, 64'h0000_0000_FFFF_0000);
    step(1'b0, 4'b0010, 4'b0010, 16'h0050, 64'h0000_0000_1234_0000, 64'h0000_0000_A5C3_0000);
    step(1'b0, 4'b0010, 4'b0000, 16'h0000, 64'h0000_0000_1234_0000, 64'h0);
    idle(2);
    chk("masked_lat1", 64'(obs1), 64'h0000_0000_0000_F5F3);
    chk("masked_lat2", 64'(obs2), 64'h0000_0000_0000_F5F3);
    step(1'b0, 4'b0010, 4'b0010, 16'h0000, 64'h0000_0000_1234_0000, 64'h0);
    step(1'b0, 4'b0010, 4'b0000, 16'h0000, 64'h0000_0000_1234_0000, 64'h0);
    idle(2);
    chk("zero_mask", 64'(obs1), 64'h0000_0000_0000_F5F3);

    // write then immediate read of the same address from another channel
    step(1'b0, 4'b0100, 4'b0100, 16'h0F00, 64'h0000_00FF_0000_0000, 64'h0000_BEEF_0000_0000);
    step(1'b0, 4'b0010, 4'b0000, 16'h0000, 64'h0000_0000_00FF_0000, 64'h0);
    idle(2);
    chk("wr_then_rd_lat1", 64'(obs1), 64'h0000_0000_0000_BEEF);
    chk("wr_then_rd_lat2", 64'(obs2), 64'h0000_0000_0000_BEEF);

    // reset while a read is in flight
    step(1'b0, 4'b0010, 4'b0, 16'h0, {16'd0, 16'd0, 16'd1, 16'd0}, 64'h0);
    step(1'b1, 4'b0, 4'b0, 16'h0, 64'h0, 64'h0);
    step(1'b1, 4'b0, 4'b0, 16'h0, 64'h0, 64'h0);
    idle(2);
    step(1'b0, 4'b0110, 4'b0, 16'h0, {16'd0, 16'd2, 16'd1, 16'd0}, 64'h0);
    chk("post_reset_ch1_first", 64'(obs_ack), 64'h2);
    idle(3);

    // randomized traffic over a preloaded address window
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NC; c++) begin
        ad[c*16 +: 16] = 16'($urandom_range(0, 7));
        dt[c*16 +: 16] = 16'($urandom);
      end
      step(($urandom_range(0, 49) == 0), 4'($urandom), 4'($urandom), 16'($urandom), ad, dt);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
